bullet_scheduler: RTL and testbench

BULLET_SCHEDULER -- requirements
Module: bullet_scheduler

---
 rtl/tank_pkg.sv | 32 +++
 rtl/bullet_slot.sv | 98 +++++++++
 rtl/bullet_scheduler.sv | 231 +++++++++++++++++++++++
 tb/tb_bullet_scheduler.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/tank_pkg.sv
// -----------------------------------------------------------------------------
// tank_pkg
// Shared constants and types for the tank game bullet logic: slot count,
// per-tank bullet cap, bullet lifetime, the off-screen park coordinate, the
// visible screen limits and the per-slot record layout.
// -----------------------------------------------------------------------------
package tank_pkg;

    localparam int          NUM_SLOTS    = 6;
    localparam int          MAX_PER_TANK = 3;
    localparam logic [7:0]  LIFETIME     = 8'd240;
    localparam logic [9:0]  PARK         = 10'h3FF;
    localparam logic [9:0]  SCREEN_W     = 10'd640;
    localparam logic [9:0]  SCREEN_H     = 10'd480;

    // One bullet slot. vx/vy are 3-bit two's complement per-frame steps.
    typedef struct packed {
        logic       active;
        logic       owner;
        logic [9:0] x;
        logic [9:0] y;
        logic [2:0] vx;
        logic [2:0] vy;
        logic [7:0] life;
    } slot_t;

    // Advance a 10-bit coordinate by a sign-extended 3-bit step, modulo 2^10.
    function automatic logic [9:0] step_pos(input logic [9:0] pos, input logic [2:0] v);
        return pos + {{7{v[2]}}, v};
    endfunction

endpackage

// File: rtl/bullet_slot.sv
// -----------------------------------------------------------------------------
// bullet_slot
// Registers and update logic for a single bullet slot: allocation load,
// per-frame movement, lifetime expiry, off-screen expiry and kill.
// An inactive slot always holds PARK_POS in x/y so its position outputs keep
// the bullet off-screen without extra muxing.
//
// Ports
//   Clk, Reset            clock, asynchronous active-high reset
//   frame_tick            one-cycle pulse per video frame
//   alloc                 load a new bullet this cycle (slot is free)
//   alloc_owner           0 = tank 1, 1 = tank 2
//   alloc_x/y, alloc_vx/vy spawn position and velocity
//   kill                  hit pulse, frees the slot if active
//   active, owner         registered slot state
//   pos_x, pos_y          registered bullet position (PARK_POS when free)
//   active_nxt, owner_nxt next-state view, used for registered counts
// -----------------------------------------------------------------------------
module bullet_slot
    import tank_pkg::*;
#(
    parameter logic [7:0] LIFE_INIT = 8'd240,
    parameter logic [9:0] PARK_POS  = 10'h3FF
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_tick,
    input  logic       alloc,
    input  logic       alloc_owner,
    input  logic [9:0] alloc_x,
    input  logic [9:0] alloc_y,
    input  logic [2:0] alloc_vx,
    input  logic [2:0] alloc_vy,
    input  logic       kill,
    output logic       active,
    output logic       owner,
    output logic [9:0] pos_x,
    output logic [9:0] pos_y,
    output logic       active_nxt,
    output logic       owner_nxt
);

    slot_t      slot_r;
    slot_t      slot_nxt_s;
    slot_t      parked_s;
    logic [9:0] nx_s;
    logic [9:0] ny_s;

    // Next-state: allocation wins, then kill (no movement), then frame update.
    always_comb begin
        parked_s        = '{active: 1'b0, owner: 1'b0, x: PARK_POS, y: PARK_POS,
                            vx: 3'd0, vy: 3'd0, life: 8'd0};
        nx_s            = step_pos(slot_r.x, slot_r.vx);
        ny_s            = step_pos(slot_r.y, slot_r.vy);
        slot_nxt_s      = slot_r;
        if (alloc) begin
            slot_nxt_s.active = 1'b1;
            slot_nxt_s.owner  = alloc_owner;
            slot_nxt_s.x      = alloc_x;
            slot_nxt_s.y      = alloc_y;
            slot_nxt_s.vx     = alloc_vx;
            slot_nxt_s.vy     = alloc_vy;
            slot_nxt_s.life   = LIFE_INIT;
        end else if (slot_r.active && kill) begin
            slot_nxt_s = parked_s;
        end else if (slot_r.active && frame_tick) begin
            // Freed on the tick that would reach life 0 or leave the screen;
            // a negative wrap lands at >= 1020, so it is caught by the same test.
            if ((slot_r.life == 8'd1) || (nx_s >= SCREEN_W) || (ny_s >= SCREEN_H)) begin
                slot_nxt_s = parked_s;
            end else begin
                slot_nxt_s.x    = nx_s;
                slot_nxt_s.y    = ny_s;
                slot_nxt_s.life = slot_r.life - 8'd1;
            end
        end else begin
            slot_nxt_s = slot_r;
        end
    end

    // Slot state register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            slot_r <= '{active: 1'b0, owner: 1'b0, x: PARK_POS, y: PARK_POS,
                        vx: 3'd0, vy: 3'd0, life: 8'd0};
        end else begin
            slot_r <= slot_nxt_s;
        end
    end

    assign active     = slot_r.active;
    assign owner      = slot_r.owner;
    assign pos_x      = slot_r.x;
    assign pos_y      = slot_r.y;
    assign active_nxt = slot_nxt_s.active;
    assign owner_nxt  = slot_nxt_s.owner;

endmodule

// File: rtl/bullet_scheduler.sv
// -----------------------------------------------------------------------------
// bullet_scheduler
// Shares NUM_SLOTS bullet slots between two tanks. Rising fire edges set a
// one-deep pending flag per tank; each cycle at most one pending tank is
// granted the lowest free slot, with round-robin only when both are eligible.
// Requests from a tank at its cap, or with no free slot, are dropped.
// The b*x/b*y port list is fixed at six slots.
//
// Ports
//   Clk, Reset              clock, asynchronous active-high reset
//   frame_tick              one-cycle pulse per video frame
//   fire1, fire2            fire key levels (tank 1 red, tank 2 green)
//   t1gx..t2gy              gun-tip spawn coordinates
//   t1vx..t2vy              signed per-frame velocity, sampled at grant
//   kill                    per-slot hit pulse
//   b1x..b6x, b1y..b6y      bullet positions (PARK when slot inactive)
//   slot_active, slot_owner slot occupancy and owner (1 = tank 2)
//   grant1, grant2          one-cycle allocation pulse
//   count1, count2          active bullets per tank
// -----------------------------------------------------------------------------
module bullet_scheduler #(
    parameter int         NUM_SLOTS    = tank_pkg::NUM_SLOTS,
    parameter int         MAX_PER_TANK = tank_pkg::MAX_PER_TANK,
    parameter logic [7:0] LIFETIME     = tank_pkg::LIFETIME,
    parameter logic [9:0] PARK         = tank_pkg::PARK
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_tick,
    input  logic        fire1,
    input  logic        fire2,
    input  logic [9:0]  t1gx,
    input  logic [9:0]  t1gy,
    input  logic [9:0]  t2gx,
    input  logic [9:0]  t2gy,
    input  logic [2:0]  t1vx,
    input  logic [2:0]  t1vy,
    input  logic [2:0]  t2vx,
    input  logic [2:0]  t2vy,
    input  logic [5:0]  kill,
    output logic [9:0]  b1x,
    output logic [9:0]  b2x,
    output logic [9:0]  b3x,
    output logic [9:0]  b4x,
    output logic [9:0]  b5x,
    output logic [9:0]  b6x,
    output logic [9:0]  b1y,
    output logic [9:0]  b2y,
    output logic [9:0]  b3y,
    output logic [9:0]  b4y,
    output logic [9:0]  b5y,
    output logic [9:0]  b6y,
    output logic [5:0]  slot_active,
    output logic [5:0]  slot_owner,
    output logic        grant1,
    output logic        grant2,
    output logic [1:0]  count1,
    output logic [1:0]  count2
);

    localparam int         IDX_W = $clog2(NUM_SLOTS);
    localparam logic [1:0] CAP   = 2'(MAX_PER_TANK);

    logic                 prev1_r, prev2_r;
    logic                 pend1_r, pend2_r;
    logic                 prio_r;            // 0 favours tank 1, 1 favours tank 2
    logic                 grant1_r, grant2_r;
    logic [1:0]           count1_r, count2_r;

    logic                 edge1_s, edge2_s;
    logic                 elig1_s, elig2_s;
    logic                 gnt1_s, gnt2_s;
    logic                 prio_nxt_s;
    logic                 pend1_nxt_s, pend2_nxt_s;
    logic                 any_free_s;
    logic [IDX_W-1:0]     free_idx_s;
    logic [NUM_SLOTS-1:0] alloc_s;
    logic [9:0]           alloc_x_s, alloc_y_s;
    logic [2:0]           alloc_vx_s, alloc_vy_s;
    logic [1:0]           cnt1_s, cnt2_s;

    logic [NUM_SLOTS-1:0] act_s, own_s, act_nxt_s, own_nxt_s;
    logic [9:0]           x_s [NUM_SLOTS];
    logic [9:0]           y_s [NUM_SLOTS];

    assign edge1_s = fire1 & ~prev1_r;
    assign edge2_s = fire2 & ~prev2_r;

    // Lowest-index free slot; uses registered occupancy so a slot freed this
    // cycle only becomes allocatable in the next one.
    always_comb begin
        any_free_s = |(~act_s);
        free_idx_s = {IDX_W{1'b0}};
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!act_s[i]) begin
                free_idx_s = IDX_W'(i);
            end else begin
                free_idx_s = free_idx_s;
            end
        end
    end

    // Arbitration: round-robin only on contest, pending drop when ineligible.
    always_comb begin
        elig1_s    = pend1_r && (count1_r < CAP) && any_free_s;
        elig2_s    = pend2_r && (count2_r < CAP) && any_free_s;
        gnt1_s     = 1'b0;
        gnt2_s     = 1'b0;
        prio_nxt_s = prio_r;
        case ({elig1_s, elig2_s})
            2'b11: begin
                if (prio_r == 1'b0) begin
                    gnt1_s     = 1'b1;
                    prio_nxt_s = 1'b1;
                end else begin
                    gnt2_s     = 1'b1;
                    prio_nxt_s = 1'b0;
                end
            end
            2'b10:   gnt1_s = 1'b1;
            2'b01:   gnt2_s = 1'b1;
            default: begin
                gnt1_s = 1'b0;
                gnt2_s = 1'b0;
            end
        endcase

        // A pending tank that lost the contest stays pending; edges while
        // pending are absorbed.
        if (pend1_r) begin
            pend1_nxt_s = !(gnt1_s || !elig1_s);
        end else begin
            pend1_nxt_s = edge1_s;
        end
        if (pend2_r) begin
            pend2_nxt_s = !(gnt2_s || !elig2_s);
        end else begin
            pend2_nxt_s = edge2_s;
        end
    end

    // Allocation payload and one-hot slot select.
    always_comb begin
        alloc_x_s  = gnt2_s ? t2gx : t1gx;
        alloc_y_s  = gnt2_s ? t2gy : t1gy;
        alloc_vx_s = gnt2_s ? t2vx : t1vx;
        alloc_vy_s = gnt2_s ? t2vy : t1vy;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            alloc_s[i] = (gnt1_s || gnt2_s) && (free_idx_s == IDX_W'(i));
        end
    end

    // Per-owner population of next-state occupancy, so counts track slots.
    always_comb begin
        cnt1_s = 2'd0;
        cnt2_s = 2'd0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            cnt1_s = cnt1_s + {1'b0, act_nxt_s[i] & ~own_nxt_s[i]};
            cnt2_s = cnt2_s + {1'b0, act_nxt_s[i] &  own_nxt_s[i]};
        end
    end

    // Scheduler state registers.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            prev1_r  <= 1'b0;
            prev2_r  <= 1'b0;
            pend1_r  <= 1'b0;
            pend2_r  <= 1'b0;
            prio_r   <= 1'b0;
            grant1_r <= 1'b0;
            grant2_r <= 1'b0;
            count1_r <= 2'd0;
            count2_r <= 2'd0;
        end else begin
            prev1_r  <= fire1;
            prev2_r  <= fire2;
            pend1_r  <= pend1_nxt_s;
            pend2_r  <= pend2_nxt_s;
            prio_r   <= prio_nxt_s;
            grant1_r <= gnt1_s;
            grant2_r <= gnt2_s;
            count1_r <= cnt1_s;
            count2_r <= cnt2_s;
        end
    end

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
        bullet_slot #(
            .LIFE_INIT (LIFETIME),
            .PARK_POS  (PARK)
        ) u_slot (
            .Clk         (Clk),
            .Reset       (Reset),
            .frame_tick  (frame_tick),
            .alloc       (alloc_s[g]),
            .alloc_owner (gnt2_s),
            .alloc_x     (alloc_x_s),
            .alloc_y     (alloc_y_s),
            .alloc_vx    (alloc_vx_s),
            .alloc_vy    (alloc_vy_s),
            .kill        (kill[g]),
            .active      (act_s[g]),
            .owner       (own_s[g]),
            .pos_x       (x_s[g]),
            .pos_y       (y_s[g]),
            .active_nxt  (act_nxt_s[g]),
            .owner_nxt   (own_nxt_s[g])
        );
    end

    assign slot_active = act_s;
    assign slot_owner  = own_s;
    assign grant1      = grant1_r;
    assign grant2      = grant2_r;
    assign count1      = count1_r;
    assign count2      = count2_r;
    assign b1x = x_s[0];
    assign b2x = x_s[1];
    assign b3x = x_s[2];
    assign b4x = x_s[3];
    assign b5x = x_s[4];
    assign b6x = x_s[5];
    assign b1y = y_s[0];
    assign b2y = y_s[1];
    assign b3y = y_s[2];
    assign b4y = y_s[3];
    assign b5y = y_s[4];
    assign b6y = y_s[5];

endmodule

// File: tb/tb_bullet_scheduler.sv
// -----------------------------------------------------------------------------
// tb_bullet_scheduler
// Directed scenarios for bullet_scheduler with hand-computed expectations.
// Inputs change and outputs are sampled just after the falling clock edge.
// -----------------------------------------------------------------------------
module tb_bullet_scheduler;

    localparam logic [9:0] PARK = 10'h3FF;

    logic       Clk, Reset, frame_tick, fire1, fire2;
    logic [9:0] t1gx, t1gy, t2gx, t2gy;
    logic [2:0] t1vx, t1vy, t2vx, t2vy;
    logic [5:0] kill;
    logic [9:0] b1x, b2x, b3x, b4x, b5x, b6x, b1y, b2y, b3y, b4y, b5y, b6y;
    logic [5:0] slot_active, slot_owner;
    logic       grant1, grant2;
    logic [1:0] count1, count2;

    int pass_cnt  = 0;
    int total_cnt = 0;

    bullet_scheduler dut (
        .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick),
        .fire1(fire1), .fire2(fire2),
        .t1gx(t1gx), .t1gy(t1gy), .t2gx(t2gx), .t2gy(t2gy),
        .t1vx(t1vx), .t1vy(t1vy), .t2vx(t2vx), .t2vy(t2vy),
        .kill(kill),
        .b1x(b1x), .b2x(b2x), .b3x(b3x), .b4x(b4x), .b5x(b5x), .b6x(b6x),
        .b1y(b1y), .b2y(b2y), .b3y(b3y), .b4y(b4y), .b5y(b5y), .b6y(b6y),
        .slot_active(slot_active), .slot_owner(slot_owner),
        .grant1(grant1), .grant2(grant2),
        .count1(count1), .count2(count2)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic step();
        @(negedge Clk);
    endtask

    task automatic do_reset();
        Reset = 1'b1; frame_tick = 1'b0; fire1 = 1'b0; fire2 = 1'b0; kill = 6'd0;
        t1gx = 10'd0; t1gy = 10'd0; t2gx = 10'd0; t2gy = 10'd0;
        t1vx = 3'd0; t1vy = 3'd0; t2vx = 3'd0; t2vy = 3'd0;
        step(); step();
        Reset = 1'b0;
        step();
    endtask

    // Single fire edge for tank (0 = tank 1); returns in the grant cycle.
    task automatic fire(input bit tank);
        if (tank == 1'b0) fire1 = 1'b1; else fire2 = 1'b1;
        step();
        fire1 = 1'b0; fire2 = 1'b0;
        step();
    endtask

    task automatic test_reset();
        do_reset();
        total_cnt++; if (slot_active !== 6'd0) $display("FAIL reset_active: got %b want 000000", slot_active); else pass_cnt++;
        total_cnt++; if (count1 !== 2'd0 || count2 !== 2'd0) $display("FAIL reset_counts: got %0d/%0d want 0/0", count1, count2); else pass_cnt++;
        total_cnt++; if (grant1 !== 1'b0 || grant2 !== 1'b0) $display("FAIL reset_grants: got %b%b want 00", grant1, grant2); else pass_cnt++;
        total_cnt++; if (b1x !== PARK || b6y !== PARK) $display("FAIL reset_park: got %h/%h want 3ff", b1x, b6y); else pass_cnt++;
    endtask

    task automatic test_single_fire();
        do_reset();
        t1gx = 10'd100; t1gy = 10'd200; t1vx = 3'd2; t1vy = 3'd0;
        fire1 = 1'b1;
        step();
        total_cnt++; if (grant1 !== 1'b0) $display("FAIL single_early: got %b want 0", grant1); else pass_cnt++;
        fire1 = 1'b0;
        step();
        total_cnt++; if (grant1 !== 1'b1) $display("FAIL single_grant: got %b want 1", grant1); else pass_cnt++;
        total_cnt++; if (slot_active !== 6'b000001 || slot_owner[0] !== 1'b0) $display("FAIL single_slot: got %b owner %b want 000001 owner 0", slot_active, slot_owner[0]); else pass_cnt++;
        total_cnt++; if (b1x !== 10'd100 || b1y !== 10'd200 || count1 !== 2'd1) $display("FAIL single_spawn: got %0d,%0d cnt %0d want 100,200 cnt 1", b1x, b1y, count1); else pass_cnt++;
        step();
        total_cnt++; if (grant1 !== 1'b0) $display("FAIL single_pulse: got %b want 0", grant1); else pass_cnt++;
        frame_tick = 1'b1;
        step(); step(); step();
        frame_tick = 1'b0;
        total_cnt++; if (b1x !== 10'd106 || b1y !== 10'd200) $display("FAIL single_move: got %0d,%0d want 106,200", b1x, b1y); else pass_cnt++;
    endtask

    task automatic test_contest();
        do_reset();
        t1gx = 10'd10; t1gy = 10'd10; t2gx = 10'd20; t2gy = 10'd20;
        fire1 = 1'b1; fire2 = 1'b1;
        step();
        fire1 = 1'b0; fire2 = 1'b0;
        step();
        total_cnt++; if (grant1 !== 1'b1 || grant2 !== 1'b0 || slot_active !== 6'b000001) $display("FAIL contest1_first: got g%b%b act %b want g10 act 000001", grant1, grant2, slot_active); else pass_cnt++;
        step();
        total_cnt++; if (grant1 !== 1'b0 || grant2 !== 1'b1 || slot_active !== 6'b000011 || slot_owner[1] !== 1'b1) $display("FAIL contest1_second: got g%b%b act %b own %b want g01 act 000011 own1 1", grant1, grant2, slot_active, slot_owner); else pass_cnt++;
        step();
        fire1 = 1'b1; fire2 = 1'b1;
        step();
        fire1 = 1'b0; fire2 = 1'b0;
        step();
        total_cnt++; if (grant2 !== 1'b1 || grant1 !== 1'b0 || slot_active !== 6'b000111 || slot_owner[2] !== 1'b1) $display("FAIL contest2_first: got g%b%b act %b own %b want g01 act 000111", grant1, grant2, slot_active, slot_owner); else pass_cnt++;
        step();
        total_cnt++; if (grant1 !== 1'b1 || slot_active !== 6'b001111 || slot_owner[3] !== 1'b0) $display("FAIL contest2_second: got g1 %b act %b own %b want 1 001111", grant1, slot_active, slot_owner); else pass_cnt++;
        total_cnt++; if (count1 !== 2'd2 || count2 !== 2'd2) $display("FAIL contest_counts: got %0d/%0d want 2/2", count1, count2); else pass_cnt++;
    endtask

    task automatic test_cap();
        int gcnt;
        gcnt = 0;
        do_reset();
        t1gx = 10'd50; t1gy = 10'd60;
        for (int k = 0; k < 4; k++) begin
            fire1 = 1'b1;
            step(); if (grant1 === 1'b1) gcnt++;
            fire1 = 1'b0;
            step(); if (grant1 === 1'b1) gcnt++;
            step(); if (grant1 === 1'b1) gcnt++;
        end
        total_cnt++; if (gcnt != 3) $display("FAIL cap_grants: got %0d want 3", gcnt); else pass_cnt++;
        total_cnt++; if (count1 !== 2'd3 || slot_active !== 6'b000111) $display("FAIL cap_count: got %0d act %b want 3 000111", count1, slot_active); else pass_cnt++;
        t2gx = 10'd300; t2gy = 10'd100;
        fire(1'b1);
        total_cnt++; if (grant2 !== 1'b1 || slot_active !== 6'b001111 || slot_owner !== 6'b001000) $display("FAIL cap_tank2: got g%b act %b own %b want 1 001111 001000", grant2, slot_active, slot_owner); else pass_cnt++;
        total_cnt++; if (b4x !== 10'd300 || b4y !== 10'd100 || count2 !== 2'd1) $display("FAIL cap_tank2_pos: got %0d,%0d cnt %0d want 300,100 cnt 1", b4x, b4y, count2); else pass_cnt++;
        // the dropped fourth request must not resurface once room appears
        kill = 6'b000001;
        step();
        kill = 6'd0;
        total_cnt++; if (count1 !== 2'd2) $display("FAIL cap_kill_count: got %0d want 2", count1); else pass_cnt++;
        step(); step();
        total_cnt++; if (slot_active !== 6'b001110) $display("FAIL cap_dropped: got %b want 001110", slot_active); else pass_cnt++;
    endtask

    task automatic test_expiry();
        do_reset();
        t1gx = 10'd100; t1gy = 10'd200;
        fire(1'b0);
        frame_tick = 1'b1;
        repeat (239) step();
        total_cnt++; if (slot_active[0] !== 1'b1 || b1x !== 10'd100) $display("FAIL expiry_alive: got act %b x %0d want 1 100", slot_active[0], b1x); else pass_cnt++;
        step();
        frame_tick = 1'b0;
        total_cnt++; if (slot_active[0] !== 1'b0 || b1x !== PARK || count1 !== 2'd0) $display("FAIL expiry_freed: got act %b x %h cnt %0d want 0 3ff 0", slot_active[0], b1x, count1); else pass_cnt++;
        t1gx = 10'd636; t1gy = 10'd50; t1vx = 3'd3;
        fire(1'b0);
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        total_cnt++; if (slot_active[0] !== 1'b1 || b1x !== 10'd639) $display("FAIL edge_639: got act %b x %0d want 1 639", slot_active[0], b1x); else pass_cnt++;
        t1gx = 10'd638;
        fire(1'b0);
        total_cnt++; if (slot_active !== 6'b000011 || b2x !== 10'd638) $display("FAIL edge_spawn: got %b x %0d want 000011 638", slot_active, b2x); else pass_cnt++;
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        total_cnt++; if (slot_active !== 6'd0 || b1x !== PARK || b2x !== PARK) $display("FAIL edge_exit: got %b x %h/%h want 000000 3ff", slot_active, b1x, b2x); else pass_cnt++;
    endtask

    task automatic test_kill_tick();
        do_reset();
        t1gx = 10'd10; t1gy = 10'd20; t1vx = 3'd1; t1vy = 3'd1;
        fire(1'b0);
        fire(1'b0);
        total_cnt++; if (slot_active !== 6'b000011) $display("FAIL kill_setup: got %b want 000011", slot_active); else pass_cnt++;
        t2gx = 10'd400; t2gy = 10'd300;
        kill = 6'b000010; frame_tick = 1'b1;
        step();
        kill = 6'd0; frame_tick = 1'b0;
        total_cnt++; if (slot_active !== 6'b000001 || b2x !== PARK || b2y !== PARK) $display("FAIL kill_freed: got %b %h,%h want 000001 3ff,3ff", slot_active, b2x, b2y); else pass_cnt++;
        total_cnt++; if (b1x !== 10'd11 || b1y !== 10'd21 || count1 !== 2'd1) $display("FAIL kill_other_moved: got %0d,%0d cnt %0d want 11,21 cnt 1", b1x, b1y, count1); else pass_cnt++;
        fire(1'b1);
        total_cnt++; if (grant2 !== 1'b1 || slot_active !== 6'b000011 || slot_owner !== 6'b000010) $display("FAIL kill_reuse: got g%b act %b own %b want 1 000011 000010", grant2, slot_active, slot_owner); else pass_cnt++;
        total_cnt++; if (b2x !== 10'd400 || b2y !== 10'd300) $display("FAIL kill_reuse_pos: got %0d,%0d want 400,300", b2x, b2y); else pass_cnt++;
        kill = 6'b100000;
        step();
        kill = 6'd0;
        total_cnt++; if (slot_active !== 6'b000011) $display("FAIL kill_inactive: got %b want 000011", slot_active); else pass_cnt++;
    endtask

    task automatic test_reset_midflight();
        do_reset();
        t1gx = 10'd100; t1gy = 10'd100; t1vx = 3'd1;
        t2gx = 10'd200; t2gy = 10'd200; t2vy = 3'd1;
        fire1 = 1'b1; fire2 = 1'b1;
        step();
        fire1 = 1'b0; fire2 = 1'b0;
        step(); step();
        fire(1'b0);
        fire(1'b1);
        total_cnt++; if (slot_active !== 6'b001111 || count1 !== 2'd2 || count2 !== 2'd2) $display("FAIL mid_setup: got %b cnt %0d/%0d want 001111 2/2", slot_active, count1, count2); else pass_cnt++;
        #2;
        Reset = 1'b1; fire1 = 1'b1; fire2 = 1'b1;
        #1;
        total_cnt++; if (slot_active !== 6'd0 || count1 !== 2'd0 || count2 !== 2'd0) $display("FAIL mid_async: got %b cnt %0d/%0d want 000000 0/0", slot_active, count1, count2); else pass_cnt++;
        total_cnt++; if (b1x !== PARK || b4y !== PARK) $display("FAIL mid_park: got %h/%h want 3ff", b1x, b4y); else pass_cnt++;
        step(); step();
        Reset = 1'b0;
        step();
        total_cnt++; if (grant1 !== 1'b0 || grant2 !== 1'b0) $display("FAIL mid_no_grant: got %b%b want 00", grant1, grant2); else pass_cnt++;
        step();
        total_cnt++; if (grant1 !== 1'b1 || grant2 !== 1'b0 || slot_active !== 6'b000001) $display("FAIL mid_prio: got g%b%b act %b want g10 000001", grant1, grant2, slot_active); else pass_cnt++;
        step();
        total_cnt++; if (grant2 !== 1'b1 || slot_owner !== 6'b000010) $display("FAIL mid_second: got g2 %b own %b want 1 000010", grant2, slot_owner); else pass_cnt++;
        fire1 = 1'b0; fire2 = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_single_fire();
        test_contest();
        test_cap();
        test_expiry();
        test_kill_tick();
        test_reset_midflight();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
